adaptive_threshold_engine: RTL and testbench
============================================

Name: adaptive_threshold_engine

Overview:
Parametrised controller and result merger for the adaptive-threshold pipeline.
- Sequences NUM_LANES box-filter lanes through IDLE/RUN/DRAIN/DONE; start/done handshake; re-runnable without reset.
- Merges per-lane binary result writes into one display write port through per-lane FIFOs and a round-robin arbiter, so simultaneous lane writes are never lost.
- Sits between the lane array and the VGA frame-buffer writer; adds output inversion and overflow reporting.

Parameters:
NUM_LANES_BITS, 2, log2 of lane count
NUM_LANES, 2**NUM_LANES_BITS, number of parallel filter lanes
WIDTH_BITS, 8, column coordinate width
HEIGHT_BITS, 8, row coordinate width
FIFO_DEPTH_BITS, 2, log2 of per-lane result FIFO depth (depth D = 2**FIFO_DEPTH_BITS)
C_BITS, 5, width of threshold offset constant

Ports:
clock  in  1  system clock
not_reset  in  1  synchronous active-low reset, sampled on posedge clock
start  in  1  single-cycle run request; honoured in IDLE and DONE only
cfg_c  in  C_BITS  threshold offset; latched on accepted start
cfg_invert  in  1  invert binary output; latched on accepted start
lane_col  in  NUM_LANES*WIDTH_BITS  per-lane result column, lane i at [i*WIDTH_BITS +: WIDTH_BITS]
lane_row  in  NUM_LANES*HEIGHT_BITS  per-lane result row, same packing
lane_data  in  NUM_LANES  per-lane binary result
lane_wren  in  NUM_LANES  per-lane result write strobe
lane_finished  in  NUM_LANES  per-lane done level
lane_stall  out  NUM_LANES  lane i must not write next cycle
global_state  out  3  broadcast state code to lanes
c_out  out  C_BITS  latched C to lanes
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE
oX  out  HEIGHT_BITS  write row (display X)
oY  out  WIDTH_BITS  write column (display Y)
oR, oG, oB  out  3 each  pixel colour, all bits = data XOR invert
oWren  out  1  display write strobe
LEDR  out  10  {c_latched, overflow, one-hot state[3:0]}

Behaviour:
- Reset: all registers update only on clock edges with not_reset=0. Outputs: state IDLE, global_state 0, c_out 0, invert 0, FIFOs empty, rr pointer 0, oWren 0, oX/oY/oR/oG/oB 0, busy 0, done 0, overflow 0, lane_stall 0, LEDR {0,0,0001}. Reset mid-run discards all FIFO contents.
- States/codes: IDLE=0, RUN=1, DRAIN=2, DONE=3; one-hot LEDR[3:0] = 0001/0010/0100/1000.
- IDLE or DONE + start: latch cfg_c, cfg_invert; clear overflow and finished-sticky bits -> RUN. Start ignored in RUN/DRAIN.
- RUN: fin_sticky[i] set on lane_finished[i]. When all bits of fin_sticky are set (including bits set this cycle) -> DRAIN.
- DRAIN: when all FIFOs are empty and no pop is in progress this cycle -> DONE next cycle. The last oWren occurs before done rises.
- Lane FIFO i: push on lane_wren[i] if count<D. Push while count==D is dropped and sets sticky overflow, even if a pop occurs the same cycle. Push and pop in the same cycle are allowed otherwise. Writes are accepted in every state; overflow clears only on start or reset.
- lane_stall[i] = (count_i >= D-1), registered from current count.
- Arbiter: each cycle, among non-empty FIFOs, grant the first lane at or after rr; pop it; rr <= grant+1 mod NUM_LANES. If none are non-empty, rr holds.
- Output register: loaded with the popped entry next cycle; oWren=1 for exactly that cycle, else 0. Coordinates and colour hold their last value when oWren=0.
- Latency: uncontended write in cycle t -> oWren in cycle t+2. Throughput is one pixel per cycle aggregate.
- Colour: oR=oG=oB={3{data ^ invert_latched}}.

Decomposition:
- Package adaptive_threshold_pkg: state codes (IDLE/RUN/DRAIN/DONE), LEDR one-hot constants, default C_BITS.
- Sub-module lane_result_fifo: one per lane via generate, parametrised by entry width (WIDTH_BITS+HEIGHT_BITS+1) and FIFO_DEPTH_BITS. Provides count, full, empty outputs.
- Arbiter and FSM stay in this module.

Test Plan:
- Reset then start with cfg_c=5'd9, invert=0 -> next cycle global_state=1, c_out=9, LEDR=10'b01001_00010, busy=1.
- All 4 lanes write in the same cycle t (lane i data=i&1, row=i, col=10+i) -> oWren cycles t+2..t+5 in lane order 0,1,2,3, oR=000,111,000,111, no overflow.
- Lane 2 writes every cycle for 6 cycles with no contention, D=4 -> never full, lane_stall[2] stays 0, oWren continuous from 2 cycles after the first write.
- Lanes 0,1 write every cycle for 8 cycles -> lane_stall rises at count 3; ignoring stall causes drops, LEDR[4]=1, and fewer than 16 oWren pulses.
- lane_finished asserted at different cycles while FIFOs still hold data -> DRAIN, done rises one cycle after the final oWren, LEDR[3:0]=1000. Second start with invert=1 -> output colours inverted.
- not_reset=0 for one cycle mid-DRAIN with FIFOs non-empty -> next cycle IDLE, oWren=0, no further writes emerge.

Source files
------------

// File: rtl/adaptive_threshold_pkg.sv
// Shared state codes and status-LED encodings for the adaptive-threshold
// controller and its result merger.
package adaptive_threshold_pkg;

    localparam int DEFAULT_C_BITS = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3
    } state_e;

    localparam logic [3:0] LED_IDLE  = 4'b0001;
    localparam logic [3:0] LED_RUN   = 4'b0010;
    localparam logic [3:0] LED_DRAIN = 4'b0100;
    localparam logic [3:0] LED_DONE  = 4'b1000;

    function automatic logic [3:0] state_onehot(input state_e s);
        case (s)
            ST_RUN:   return LED_RUN;
            ST_DRAIN: return LED_DRAIN;
            ST_DONE:  return LED_DONE;
            default:  return LED_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/adaptive_threshold_engine_if.sv
// Lane-array result bus and display write port of the threshold engine.
interface adaptive_threshold_engine_if #(
    parameter int NUM_LANES   = 4,
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int C_BITS      = 5
);
    logic [NUM_LANES*WIDTH_BITS-1:0]  lane_col;
    logic [NUM_LANES*HEIGHT_BITS-1:0] lane_row;
    logic [NUM_LANES-1:0]             lane_data;
    logic [NUM_LANES-1:0]             lane_wren;
    logic [NUM_LANES-1:0]             lane_finished;
    logic [NUM_LANES-1:0]             lane_stall;
    logic [2:0]                       global_state;
    logic [C_BITS-1:0]                c_out;
    logic [HEIGHT_BITS-1:0]           oX;
    logic [WIDTH_BITS-1:0]            oY;
    logic [2:0]                       oR;
    logic [2:0]                       oG;
    logic [2:0]                       oB;
    logic                             oWren;

    // The lane array / display side drives lane results and consumes writes.
    modport master (
        output lane_col, lane_row, lane_data, lane_wren, lane_finished,
        input  lane_stall, global_state, c_out, oX, oY, oR, oG, oB, oWren
    );

    modport slave (
        input  lane_col, lane_row, lane_data, lane_wren, lane_finished,
        output lane_stall, global_state, c_out, oX, oY, oR, oG, oB, oWren
    );

endinterface

// File: rtl/lane_result_fifo.sv
// Small per-lane result FIFO; pushes into a full FIFO are dropped even when
// a pop happens in the same cycle.
module lane_result_fifo #(
    parameter int ENTRY_BITS = 17,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clock,
    input  logic                  not_reset,
    input  logic                  push,
    input  logic [ENTRY_BITS-1:0] push_data,
    input  logic                  pop,
    output logic [ENTRY_BITS-1:0] pop_data,
    output logic [DEPTH_BITS:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [ENTRY_BITS-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == (DEPTH_BITS + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!not_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define validity, so clearing it would only add reset fan-out.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adaptive_threshold_engine.sv
// Run sequencer for the filter lanes plus a round-robin merger of per-lane
// binary results onto the single frame-buffer write port.
module adaptive_threshold_engine
    import adaptive_threshold_pkg::*;
#(
    parameter int NUM_LANES_BITS  = 2,
    parameter int NUM_LANES       = 2 ** NUM_LANES_BITS,
    parameter int WIDTH_BITS      = 8,
    parameter int HEIGHT_BITS     = 8,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int C_BITS          = DEFAULT_C_BITS
) (
    input  logic                        clock,
    input  logic                        not_reset,
    input  logic                        start,
    input  logic [C_BITS-1:0]           cfg_c,
    input  logic                        cfg_invert,
    adaptive_threshold_engine_if.slave  bus,
    output logic                        busy,
    output logic                        done,
    output logic [9:0]                  LEDR
);

    localparam int ENTRY_BITS = HEIGHT_BITS + WIDTH_BITS + 1;
    localparam int DEPTH      = 1 << FIFO_DEPTH_BITS;
    localparam int CNT_BITS   = FIFO_DEPTH_BITS + 1;

    state_e                    state;
    state_e                    state_next;
    logic [C_BITS-1:0]         c_q;
    logic                      invert_q;
    logic                      overflow_q;
    logic                      overflow_hit;
    logic                      start_ok;
    logic [NUM_LANES-1:0]      fin_q;
    logic [NUM_LANES-1:0]      fin_all;

    logic [NUM_LANES-1:0]      fifo_full;
    logic [NUM_LANES-1:0]      fifo_empty;
    logic [NUM_LANES-1:0]      fifo_pop;
    logic [NUM_LANES-1:0]      stall_q;
    logic [ENTRY_BITS-1:0]     fifo_data  [NUM_LANES];
    logic [CNT_BITS-1:0]       fifo_count [NUM_LANES];

    logic [NUM_LANES_BITS-1:0] rr_q;
    logic [NUM_LANES_BITS-1:0] cand;
    logic [NUM_LANES_BITS-1:0] grant;
    logic                      grant_valid;
    logic [ENTRY_BITS-1:0]     head;

    logic [HEIGHT_BITS-1:0]    x_q;
    logic [WIDTH_BITS-1:0]     y_q;
    logic                      pix_q;
    logic                      wren_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_result_fifo #(
            .ENTRY_BITS (ENTRY_BITS),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clock     (clock),
            .not_reset (not_reset),
            .push      (bus.lane_wren[g]),
            .push_data ({bus.lane_row[g*HEIGHT_BITS +: HEIGHT_BITS],
                         bus.lane_col[g*WIDTH_BITS +: WIDTH_BITS],
                         bus.lane_data[g]}),
            .pop       (fifo_pop[g]),
            .pop_data  (fifo_data[g]),
            .count     (fifo_count[g]),
            .full      (fifo_full[g]),
            .empty     (fifo_empty[g])
        );
    end

    assign overflow_hit = |(bus.lane_wren & fifo_full);

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        fin_all    = fin_q | bus.lane_finished;
        start_ok   = start && (state == ST_IDLE || state == ST_DONE);
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_RUN;
            ST_RUN:           if (&fin_all) state_next = ST_DRAIN;
            ST_DRAIN:         if (&fifo_empty && !grant_valid) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!not_reset) begin
            state      <= ST_IDLE;
            c_q        <= '0;
            invert_q   <= 1'b0;
            overflow_q <= 1'b0;
            fin_q      <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                c_q        <= cfg_c;
                invert_q   <= cfg_invert;
                fin_q      <= '0;
                overflow_q <= overflow_hit;
            end else begin
                if (overflow_hit)     overflow_q <= 1'b1;
                if (state == ST_RUN)  fin_q      <= fin_all;
            end
        end
    end

    // Stall warns one entry early because the lane sees it a cycle late.
    always_ff @(posedge clock) begin
        if (!not_reset) begin
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++)
                stall_q[i] <= (fifo_count[i] >= CNT_BITS'(DEPTH - 1));
        end
    end

    // First non-empty lane at or after the round-robin pointer wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        fifo_pop    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = rr_q + NUM_LANES_BITS'(k);
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
        if (grant_valid) fifo_pop[grant] = 1'b1;
    end

    assign head = fifo_data[grant];

    always_ff @(posedge clock) begin
        if (!not_reset) begin
            rr_q   <= '0;
            wren_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            pix_q  <= 1'b0;
        end else begin
            wren_q <= grant_valid;
            if (grant_valid) begin
                rr_q  <= grant + 1'b1;
                x_q   <= head[ENTRY_BITS-1 -: HEIGHT_BITS];
                y_q   <= head[WIDTH_BITS:1];
                pix_q <= head[0] ^ invert_q;
            end
        end
    end

    assign bus.lane_stall   = stall_q;
    assign bus.global_state = state;
    assign bus.c_out        = c_q;
    assign bus.oX           = x_q;
    assign bus.oY           = y_q;
    assign bus.oR           = {3{pix_q}};
    assign bus.oG           = {3{pix_q}};
    assign bus.oB           = {3{pix_q}};
    assign bus.oWren        = wren_q;

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign LEDR = 10'({c_q, overflow_q, state_onehot(state)});

endmodule

// File: tb/tb_adaptive_threshold_engine.sv
// Scenario bench for adaptive_threshold_engine: per-lane scoreboard queues
// filled at drive time and drained by a display-port monitor.
module tb_adaptive_threshold_engine;

    localparam int NL = 4;
    localparam int WB = 8;
    localparam int HB = 8;
    localparam int CB = 5;

    typedef logic [HB+WB+3-1:0] exp_t;

    logic          clock      = 1'b0;
    logic          not_reset  = 1'b0;
    logic          start      = 1'b0;
    logic [CB-1:0] cfg_c      = '0;
    logic          cfg_invert = 1'b0;
    logic          busy;
    logic          done;
    logic [9:0]    LEDR;

    adaptive_threshold_engine_if #(
        .NUM_LANES(NL), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .C_BITS(CB)
    ) bus_if ();

    adaptive_threshold_engine #(
        .NUM_LANES_BITS(2), .WIDTH_BITS(WB), .HEIGHT_BITS(HB),
        .FIFO_DEPTH_BITS(2), .C_BITS(CB)
    ) dut (
        .clock      (clock),
        .not_reset  (not_reset),
        .start      (start),
        .cfg_c      (cfg_c),
        .cfg_invert (cfg_invert),
        .bus        (bus_if),
        .busy       (busy),
        .done       (done),
        .LEDR       (LEDR)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   pulses = 0;
    int   last_wr_cyc = -1;
    bit   sb_en     = 1'b1;
    bit   inv_model = 1'b0;
    exp_t exp_q [NL][$];
    int   log_cyc [$];
    int   log_row [$];
    exp_t got;
    exp_t want;
    int   mon_lane;

    always @(posedge clock) cyc <= cyc + 1;

    // Display-port monitor: every write is matched against its lane's queue.
    always @(negedge clock) begin
        if (bus_if.oWren === 1'b1) begin
            pulses++;
            last_wr_cyc = cyc;
            log_cyc.push_back(cyc);
            log_row.push_back(int'(bus_if.oX));
            if (sb_en) begin
                checks++;
                got      = {bus_if.oX, bus_if.oY, bus_if.oR};
                mon_lane = int'(bus_if.oX);
                if (mon_lane >= NL || exp_q[mon_lane].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got=%h at cycle %0d", got, cyc);
                end else begin
                    want = exp_q[mon_lane].pop_front();
                    if (got !== want || bus_if.oG !== bus_if.oR || bus_if.oB !== bus_if.oR) begin
                        errors++;
                        $display("FAIL write_lane%0d got=%h g=%b b=%b expected=%h",
                                 mon_lane, got, bus_if.oG, bus_if.oB, want);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [NL-1:0] wren, input logic [NL-1:0] data,
                         input logic [NL-1:0] fin, input int col_base);
        for (int i = 0; i < NL; i++) begin
            bus_if.lane_row[i*HB +: HB] = HB'(i);
            bus_if.lane_col[i*WB +: WB] = WB'(col_base + i);
            if (sb_en && wren[i])
                exp_q[i].push_back({HB'(i), WB'(col_base + i), {3{data[i] ^ inv_model}}});
        end
        bus_if.lane_data     = data;
        bus_if.lane_wren     = wren;
        bus_if.lane_finished = fin;
    endtask

    task automatic idle(input int n);
        drive('0, '0, '0, 0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        not_reset = 1'b0;
        drive('0, '0, '0, 0);
        tick();
        tick();
        @(negedge clock);
        checks++; if (bus_if.global_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d expected=0", bus_if.global_state); end
        checks++; if (bus_if.c_out !== '0) begin errors++; $display("FAIL reset_c_out got=%0d expected=0", bus_if.c_out); end
        checks++; if (LEDR !== 10'b00000_00001) begin errors++; $display("FAIL reset_ledr got=%b expected=0000000001", LEDR); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b expected=00", busy, done); end
        checks++; if (bus_if.oWren !== 1'b0 || bus_if.lane_stall !== '0) begin errors++; $display("FAIL reset_wren_stall got=%b/%b expected=0/0", bus_if.oWren, bus_if.lane_stall); end
        checks++;
        if ({bus_if.oX, bus_if.oY, bus_if.oR, bus_if.oG, bus_if.oB} !== '0) begin
            errors++; $display("FAIL reset_pixel got=%h expected=0", {bus_if.oX, bus_if.oY, bus_if.oR});
        end
        tick();
        not_reset = 1'b1;
    endtask

    task automatic test_start();
        start = 1'b1; cfg_c = 5'd9; cfg_invert = 1'b0; inv_model = 1'b0;
        tick();
        start = 1'b0;
        @(negedge clock);
        checks++; if (bus_if.global_state !== 3'd1) begin errors++; $display("FAIL start_state got=%0d expected=1", bus_if.global_state); end
        checks++; if (bus_if.c_out !== 5'd9) begin errors++; $display("FAIL start_c_out got=%0d expected=9", bus_if.c_out); end
        checks++; if (LEDR !== 10'b01001_00010) begin errors++; $display("FAIL start_ledr got=%b expected=0100100010", LEDR); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b expected=1", busy); end
        tick();
        // A start while running must not reload the configuration.
        start = 1'b1; cfg_c = 5'd2;
        tick();
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus_if.c_out !== 5'd9 || bus_if.global_state !== 3'd1) begin
            errors++; $display("FAIL start_in_run c=%0d state=%0d expected c=9 state=1", bus_if.c_out, bus_if.global_state);
        end
        tick();
    endtask

    task automatic test_all_lanes();
        int t;
        log_cyc.delete(); log_row.delete();
        drive(4'hF, 4'b1010, '0, 10);
        t = cyc;
        tick();
        idle(7);
        checks++; if (log_cyc.size() != 4) begin errors++; $display("FAIL all_lanes_count got=%0d expected=4", log_cyc.size()); end
        for (int j = 0; j < 4 && j < log_cyc.size(); j++) begin
            checks++;
            if (log_cyc[j] != t + 2 + j || log_row[j] != j) begin
                errors++; $display("FAIL all_lanes_order%0d got cyc=%0d lane=%0d expected cyc=%0d lane=%0d",
                                   j, log_cyc[j], log_row[j], t + 2 + j, j);
            end
        end
        checks++; if (LEDR[4] !== 1'b0) begin errors++; $display("FAIL all_lanes_overflow got=%b expected=0", LEDR[4]); end
    endtask

    task automatic test_single_lane();
        int t0;
        log_cyc.delete(); log_row.delete();
        t0 = cyc;
        for (int k = 0; k < 6; k++) begin
            drive(4'b0100, 4'((k & 1) << 2), '0, 18 + k);
            @(negedge clock);
            checks++; if (bus_if.lane_stall[2] !== 1'b0) begin errors++; $display("FAIL single_stall%0d got=1 expected=0", k); end
            tick();
        end
        idle(6);
        checks++; if (log_cyc.size() != 6) begin errors++; $display("FAIL single_count got=%0d expected=6", log_cyc.size()); end
        for (int j = 0; j < 6 && j < log_cyc.size(); j++) begin
            checks++;
            if (log_cyc[j] != t0 + 2 + j) begin
                errors++; $display("FAIL single_cycle%0d got=%0d expected=%0d", j, log_cyc[j], t0 + 2 + j);
            end
        end
    endtask

    task automatic test_overflow();
        int p0;
        bit stall_seen;
        p0 = pulses; stall_seen = 1'b0;
        sb_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(4'b0011, 4'b0001, '0, 30);
            @(negedge clock);
            if (bus_if.lane_stall[0] === 1'b1) stall_seen = 1'b1;
            if (k == 0) begin
                checks++; if (bus_if.lane_stall !== '0) begin errors++; $display("FAIL ovf_early_stall got=%b expected=0000", bus_if.lane_stall); end
            end
            tick();
        end
        idle(20);
        sb_en = 1'b1;
        checks++; if (!stall_seen) begin errors++; $display("FAIL ovf_stall got=0 expected=1"); end
        checks++; if (LEDR[4] !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b expected=1", LEDR[4]); end
        checks++; if (pulses - p0 >= 16 || pulses - p0 == 0) begin errors++; $display("FAIL ovf_pulses got=%0d expected 1..15", pulses - p0); end
        checks++; if (bus_if.lane_stall !== '0) begin errors++; $display("FAIL ovf_stall_clear got=%b expected=0000", bus_if.lane_stall); end
    endtask

    task automatic test_drain();
        int  p0;
        int  done_cyc;
        int  n;
        bit  seen;
        p0 = pulses; seen = 1'b0; done_cyc = -1; n = 0;
        drive(4'hF, 4'b1010, '0, 30);        tick();
        drive(4'b1000, 4'b1000, 4'b0001, 37); tick();
        drive(4'hF, 4'b0101, 4'b0010, 50);   tick();
        drive('0, '0, 4'b0100, 0);           tick();
        drive('0, '0, 4'b1000, 0);
        @(negedge clock);
        checks++; if (bus_if.global_state !== 3'd1) begin errors++; $display("FAIL drain_still_run got=%0d expected=1", bus_if.global_state); end
        tick();
        drive('0, '0, '0, 0);
        @(negedge clock);
        checks++; if (bus_if.global_state !== 3'd2) begin errors++; $display("FAIL drain_state got=%0d expected=2", bus_if.global_state); end
        while (!seen && n < 40) begin
            @(negedge clock);
            n++;
            if (done === 1'b1) begin seen = 1'b1; done_cyc = cyc; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL drain_done_timeout got=0 expected=1"); end
        checks++; if (done_cyc != last_wr_cyc + 1) begin errors++; $display("FAIL drain_done_cycle got=%0d expected=%0d", done_cyc, last_wr_cyc + 1); end
        checks++; if (pulses - p0 != 9) begin errors++; $display("FAIL drain_pulses got=%0d expected=9", pulses - p0); end
        checks++; if (LEDR[4:0] !== 5'b1_1000) begin errors++; $display("FAIL drain_ledr got=%b expected=11000", LEDR[4:0]); end
        checks++; if (busy !== 1'b0 || bus_if.global_state !== 3'd3) begin errors++; $display("FAIL drain_done_state busy=%b state=%0d expected 0/3", busy, bus_if.global_state); end
        tick();
    endtask

    task automatic test_invert();
        int p0;
        start = 1'b1; cfg_c = 5'd3; cfg_invert = 1'b1;
        tick();
        start = 1'b0; inv_model = 1'b1;
        @(negedge clock);
        checks++; if (bus_if.global_state !== 3'd1) begin errors++; $display("FAIL restart_state got=%0d expected=1", bus_if.global_state); end
        checks++; if (LEDR !== 10'b00011_00010) begin errors++; $display("FAIL restart_ledr got=%b expected=0001100010", LEDR); end
        checks++; if (bus_if.c_out !== 5'd3) begin errors++; $display("FAIL restart_c_out got=%0d expected=3", bus_if.c_out); end
        tick();
        p0 = pulses;
        drive(4'hF, 4'b1010, '0, 60);
        tick();
        idle(8);
        checks++; if (pulses - p0 != 4) begin errors++; $display("FAIL invert_pulses got=%0d expected=4", pulses - p0); end
    endtask

    task automatic test_reset_mid_drain();
        int p0;
        p0 = pulses;
        drive(4'hF, 4'b0110, 4'hF, 70);
        tick();
        drive('0, '0, '0, 0);
        not_reset = 1'b0;
        @(negedge clock);
        checks++; if (bus_if.global_state !== 3'd2) begin errors++; $display("FAIL mid_reset_pre got=%0d expected=2", bus_if.global_state); end
        tick();
        not_reset = 1'b1;
        for (int i = 0; i < NL; i++) exp_q[i].delete();
        inv_model = 1'b0;
        @(negedge clock);
        checks++; if (bus_if.global_state !== 3'd0) begin errors++; $display("FAIL mid_reset_state got=%0d expected=0", bus_if.global_state); end
        checks++; if (bus_if.oWren !== 1'b0) begin errors++; $display("FAIL mid_reset_wren got=%b expected=0", bus_if.oWren); end
        checks++; if (LEDR !== 10'b00000_00001) begin errors++; $display("FAIL mid_reset_ledr got=%b expected=0000000001", LEDR); end
        tick();
        idle(10);
        checks++; if (pulses != p0) begin errors++; $display("FAIL mid_reset_leak got=%0d expected=0", pulses - p0); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_all_lanes();
        test_single_lane();
        test_overflow();
        test_drain();
        test_invert();
        test_reset_mid_drain();
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++; $display("FAIL leftover_lane%0d got=%0d expected=0", i, exp_q[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
